// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per enabled clock)
// with sign handling, saturating overflow and active-low 7-segment decode.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last result
// CONVERT | one double-dabble step per enabled edge, counter counts down to 0
module bin2bcd_seq #(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3,
  parameter int SIGNED      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] bin,
  output logic [4*DIGITS-1:0]    bcd,
  output logic [7*DIGITS-1:0]    seg,
  output logic                   sign,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          acc_q;
  logic [WORD_LENGTH-1:0] mag_q;
  logic                   ovf_acc_q;
  logic                   sign_acc_q;

  logic [BW-1:0]          bcd_q;
  logic                   sign_q;
  logic                   overflow_q;
  logic                   done_q;

  logic                   load;
  logic                   step;
  logic                   last_step;

  logic                   neg_in;
  logic [WORD_LENGTH-1:0] mag_in;
  logic [BW-1:0]          acc_adj;
  logic [BW-1:0]          acc_next;
  logic [WORD_LENGTH-1:0] mag_next;
  logic                   lost_bit;
  logic                   ovf_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = CONVERT;
      CONVERT: if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    busy      = (state_q == CONVERT);
    load      = (state_q == IDLE) && start;
    step      = (state_q == CONVERT);
    last_step = (cnt_q == CW'(1));
  end

  // Magnitude of a two's-complement input; the most negative value maps to
  // 2^(WORD_LENGTH-1), which still fits WORD_LENGTH unsigned bits.
  always_comb begin
    neg_in = (SIGNED != 0) && bin[WORD_LENGTH-1];
    mag_in = neg_in ? ((~bin) + {{(WORD_LENGTH-1){1'b0}}, 1'b1}) : bin;
  end

  // One double-dabble step; the bit shifted out of the top digit marks overflow.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {lost_bit, acc_next, mag_next} = {acc_adj, mag_q, 1'b0};
    ovf_next = ovf_acc_q | lost_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      ovf_acc_q  <= 1'b0;
      sign_acc_q <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (enable) begin
      done_q <= 1'b0;
      if (load) begin
        cnt_q      <= CW'(WORD_LENGTH);
        acc_q      <= '0;
        mag_q      <= mag_in;
        ovf_acc_q  <= 1'b0;
        sign_acc_q <= neg_in;
      end else if (step) begin
        cnt_q     <= cnt_q - CW'(1);
        acc_q     <= acc_next;
        mag_q     <= mag_next;
        ovf_acc_q <= ovf_next;
        if (last_step) begin
          bcd_q      <= ovf_next ? {DIGITS{4'h9}} : acc_next;
          sign_q     <= sign_acc_q;
          overflow_q <= ovf_next;
          done_q     <= 1'b1;
        end
      end
    end
  end

  // Segment codes are decoded straight from the registered BCD result.
  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
  end

  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8, binary input width (>=2).
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD/7-segment digits (>=1).
REQ-003 SHALL have parameter SIGNED, default 1; 1 = bin is two's complement, 0 = bin is unsigned.
REQ-004 SHALL have ports, in order:
  clk  input  1  single clock; all state updates on the rising edge.
  reset  input  1  asynchronous, active-high reset.
  enable  input  1  1 = block advances; 0 = all registers hold.
  start  input  1  conversion request, sampled at clk rising edge.
  bin  input  WORD_LENGTH  value to convert, sampled with start.
  bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
  seg  output  7*DIGITS  7-segment codes, digit i in [7i+6:7i], bit order g..a, active-low.
  sign  output  1  1 = result is negative.
  overflow  output  1  1 = magnitude >= 10^DIGITS.
  busy  output  1  conversion in progress.
  done  output  1  one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM with states IDLE and CONVERT.
REQ-006 IDLE: on an edge with enable=1 and start=1, SHALL capture bin, compute magnitude and sign, load bit counter = WORD_LENGTH, and go to CONVERT; start=0 keeps IDLE.
REQ-007 Magnitude: SIGNED=1 with bin MSB=1 -> magnitude = two's-complement negation in WORD_LENGTH bits unsigned (bin = -2^(WORD_LENGTH-1) yields 2^(WORD_LENGTH-1)); otherwise magnitude = bin.
REQ-008 Sign: SIGNED=1 -> bin MSB; SIGNED=0 -> always 0.
REQ-009 CONVERT: each edge with enable=1 SHALL perform one double-dabble step: add 3 to every internal BCD digit >= 5, then shift the {BCD, magnitude} register left by one, and decrement the counter.
REQ-010 Overflow: if the top internal digit is >= 8 at a shift, the lost bit SHALL set a per-conversion sticky overflow flag.
REQ-011 The edge performing the WORD_LENGTH-th step SHALL return to IDLE and update bcd, seg, sign, and overflow, and SHALL set done=1 for exactly the following cycle.
REQ-012 Latency: done SHALL be high in the cycle after the WORD_LENGTH-th enabled edge after the start-sampling edge; no enable stalls -> WORD_LENGTH cycles.
REQ-013 On overflow, bcd SHALL saturate to all digits = 9 and overflow=1; otherwise bcd = exact decimal magnitude and overflow=0.
REQ-014 bcd, seg, sign, and overflow SHALL hold the previous result throughout CONVERT and until the next completion.
REQ-015 busy SHALL be 1 in every cycle the FSM is in CONVERT, and 0 otherwise.
REQ-016 start SHALL be ignored while busy=1; back-to-back start on the cycle done=1 SHALL be accepted.
REQ-017 enable=0 SHALL freeze state, counter, shift register, and all outputs, including a pending done pulse; done clears on the next enabled edge.
REQ-018 seg SHALL be registered or purely derived from registered bcd, using active-low codes 0..9:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-019 reset=1 SHALL asynchronously force IDLE, counter 0, shift register 0, bcd=0, every seg digit=1000000, sign=0, overflow=0, busy=0, done=0.
REQ-020 reset asserted mid-conversion SHALL abort the conversion with no done pulse; outputs SHALL go to reset values.
REQ-021 After reset deassertion, the first start accepted SHALL behave per REQ-006.

Verification (defaults W=8, D=3, S=1 unless stated)
REQ-022 start, bin=114 -> after 8 cycles: done pulse, bcd=0x114, sign=0, overflow=0, seg units/tens/hundreds = 0011001/1111001/1111001.
REQ-023 bin=0x81 (-127) -> bcd=0x127, sign=1; bin=0x80 -> bcd=0x128, sign=1.
REQ-024 S=0, bin=255 -> bcd=0x255, sign=0; D=2, S=0, bin=100 -> bcd=0x99, overflow=1.
REQ-025 start re-pulsed with bin=50 at cycle 3 of a conversion -> ignored; the original result is produced on time.
REQ-026 enable low for 4 cycles mid-conversion -> done is delayed by exactly 4 cycles with a correct result; reset at cycle 5 -> no done pulse, all outputs at reset values.
